// File: rtl/clint_pkg.sv
// -----------------------------------------------------------------------------
// clint_pkg
// Shared definitions for the core-local interruptor (CLINT):
//   - word offsets of the memory-mapped registers inside the CLINT window
//   - be_merge(): byte-lane write merge used by every writable register
// No ports (package).
// -----------------------------------------------------------------------------
package clint_pkg;

  localparam logic [31:0] CLINT_MSIP_OFF        = 32'h0000_0000;
  localparam logic [31:0] CLINT_MTIMECMP_LO_OFF = 32'h0000_4000;
  localparam logic [31:0] CLINT_MTIMECMP_HI_OFF = 32'h0000_4004;
  localparam logic [31:0] CLINT_MTIME_LO_OFF    = 32'h0000_BFF8;
  localparam logic [31:0] CLINT_MTIME_HI_OFF    = 32'h0000_BFFC;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// -----------------------------------------------------------------------------
// clint_timer
// Prescaler plus 64-bit free-running machine timer (mtime) with independent
// loads of the low and high halves.
// Ports:
//   clk          in   core clock
//   rst          in   synchronous active-high reset
//   i_wr_lo      in   load mtime[31:0] from i_wdata_lo this edge
//   i_wr_hi      in   load mtime[63:32] from i_wdata_hi this edge
//   i_wdata_lo   in   32-bit value for the low half (already lane-merged)
//   i_wdata_hi   in   32-bit value for the high half (already lane-merged)
//   o_mtime      out  current 64-bit mtime
// -----------------------------------------------------------------------------
module clint_timer #(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata_lo,
  input  logic [31:0] i_wdata_hi,
  output logic [63:0] o_mtime
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [63:0]   r_mtime;
  logic          w_tick;

  assign w_tick  = (r_presc == PRESC_LAST);
  assign o_mtime = r_mtime;

  // Prescaler keeps running across mtime writes so the tick cadence is stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // A write to either half suppresses the increment for the whole counter;
  // the unwritten half keeps its pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime <= '0;
    end else if (i_wr_lo || i_wr_hi) begin
      if (i_wr_lo) r_mtime[31:0]  <= i_wdata_lo;
      if (i_wr_hi) r_mtime[63:32] <= i_wdata_hi;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

endmodule

// File: rtl/clint.sv
// -----------------------------------------------------------------------------
// clint
// Core-local interruptor: memory-mapped msip, mtimecmp and mtime registers on
// the data-memory bus, producing registered software/timer interrupt levels.
// Ports:
//   clk                 in   core clock
//   rst                 in   synchronous active-high reset
//   bus_read            in   single-cycle read strobe
//   bus_write           in   single-cycle write strobe
//   bus_address         in   byte address within the CLINT window ([1:0] ignored)
//   bus_byteenable      in   write byte lanes
//   bus_writedata       in   write data
//   bus_readdata        out  read data, registered, valid the cycle after bus_read
//   software_interrupt  out  registered copy of msip[0]
//   timer_interrupt     out  registered (mtime >= mtimecmp)
// -----------------------------------------------------------------------------
module clint
  import clint_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_read,
  input  logic              bus_write,
  input  logic [ADDR_W-1:0] bus_address,
  input  logic [3:0]        bus_byteenable,
  input  logic [31:0]       bus_writedata,
  output logic [31:0]       bus_readdata,
  output logic              software_interrupt,
  output logic              timer_interrupt
);

  logic [31:0] w_word_addr;
  logic        w_unused_addr;
  logic        w_sel_msip;
  logic        w_sel_cmp_lo;
  logic        w_sel_cmp_hi;
  logic        w_sel_mt_lo;
  logic        w_sel_mt_hi;
  logic [63:0] w_mtime;
  logic [31:0] w_mtime_lo_new;
  logic [31:0] w_mtime_hi_new;
  logic [31:0] w_rdata;

  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic [31:0] r_readdata;
  logic        r_sip;
  logic        r_tip;

  // Byte offset with the sub-word bits forced to zero, widened for decode.
  assign w_word_addr   = {{(32-ADDR_W){1'b0}}, bus_address[ADDR_W-1:2], 2'b00};
  assign w_unused_addr = ^bus_address[1:0];

  assign w_sel_msip   = (w_word_addr == CLINT_MSIP_OFF);
  assign w_sel_cmp_lo = (w_word_addr == CLINT_MTIMECMP_LO_OFF);
  assign w_sel_cmp_hi = (w_word_addr == CLINT_MTIMECMP_HI_OFF);
  assign w_sel_mt_lo  = (w_word_addr == CLINT_MTIME_LO_OFF);
  assign w_sel_mt_hi  = (w_word_addr == CLINT_MTIME_HI_OFF);

  assign w_mtime_lo_new = be_merge(w_mtime[31:0],  bus_writedata, bus_byteenable);
  assign w_mtime_hi_new = be_merge(w_mtime[63:32], bus_writedata, bus_byteenable);

  clint_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_wr_lo    (bus_write && w_sel_mt_lo),
    .i_wr_hi    (bus_write && w_sel_mt_hi),
    .i_wdata_lo (w_mtime_lo_new),
    .i_wdata_hi (w_mtime_hi_new),
    .o_mtime    (w_mtime)
  );

  // Read mux from pre-edge register values; unmapped addresses read zero.
  always_comb begin
    w_rdata = '0;
    if (w_sel_msip)        w_rdata = {31'd0, r_msip};
    else if (w_sel_cmp_lo) w_rdata = r_mtimecmp[31:0];
    else if (w_sel_cmp_hi) w_rdata = r_mtimecmp[63:32];
    else if (w_sel_mt_lo)  w_rdata = w_mtime[31:0];
    else if (w_sel_mt_hi)  w_rdata = w_mtime[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
      r_readdata <= '0;
      r_sip      <= 1'b0;
      r_tip      <= 1'b0;
    end else begin
      if (bus_write) begin
        if (w_sel_msip && bus_byteenable[0]) r_msip <= bus_writedata[0];
        if (w_sel_cmp_lo)
          r_mtimecmp[31:0]  <= be_merge(r_mtimecmp[31:0],  bus_writedata, bus_byteenable);
        if (w_sel_cmp_hi)
          r_mtimecmp[63:32] <= be_merge(r_mtimecmp[63:32], bus_writedata, bus_byteenable);
      end
      if (bus_read) r_readdata <= w_rdata;
      // Interrupt levels are one register behind the architectural state.
      r_sip <= r_msip;
      r_tip <= (w_mtime >= r_mtimecmp);
    end
  end

  assign bus_readdata       = r_readdata;
  assign software_interrupt = r_sip;
  assign timer_interrupt    = r_tip;

endmodule
